uart_rx_oversampled: RTL

Parametrised UART receiver. It recovers asynchronous serial frames from a single RX line using an oversampling bit-timer, and presents each received word with a one-cycle valid strobe and error flags. It sits between the board RX pin and the byte-consuming logic. It replaces the one-bit-per-clock receiver: it decouples baud rate from the system clock, supports configurable word width, validates the start and stop bits, and can optionally check parity.

---
 rtl/uart_rx_oversampled.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with start/stop validation.
// Optional parity checking is compiled in when the macro UART_RX_PARITY_EN is
// defined; without it the frame is start + DATA_BITS + stop and o_Parity_Err
// is tied low.
// Status pulses (o_RX_Valid / o_Frame_Err / o_Parity_Err) are registered,
// mutually exclusive, and high for one cycle after the stop-bit sample.
// dbg_state exposes the FSM state encoding for observation.
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_RX_Bit,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_RX_Valid,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Busy,
    output logic [2:0]           dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 brk;       // stop bit was low; waiting for line to return high
    logic                 par_err;   // parity mismatch recorded for the current frame
    logic                 half_done;
    logic                 bit_done;
    logic                 last_bit;
    logic                 stop_tick;
    logic                 valid_d;
    logic                 ferr_d;
    logic                 perr_d;

    assign half_done = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign bit_done  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit  = (idx == IDX_W'(DATA_BITS - 1));
    assign stop_tick = (state == STOP) && !brk && bit_done;
    assign dbg_state = state;

    // Two-flop synchronizer for the asynchronous RX line; idles high out of reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Bit;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: sample points are where the bit timer wraps
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rx_s) state_next = START;
            START:  if (half_done) state_next = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_done && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: if (bit_done) state_next = STOP;
            STOP: begin
                if (brk) begin
                    if (rx_s) state_next = IDLE;
                end else if (bit_done && rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: busy level and the next values of the status pulses
    always_comb begin
        o_Busy  = (state != IDLE);
        valid_d = stop_tick && rx_s && !par_err;
        perr_d  = stop_tick && rx_s && par_err;
        ferr_d  = stop_tick && !rx_s;
    end

    // Bit timer, bit index, shift register, break flag and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            brk         <= 1'b0;
            o_RX_Byte   <= '0;
            o_RX_Valid  <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_RX_Valid  <= valid_d;
            o_Frame_Err <= ferr_d;
            if (valid_d) o_RX_Byte <= shift;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    brk <= 1'b0;
                end
                START: cnt <= half_done ? '0 : cnt + 1'b1;
                DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        // LSB arrives first, so shifting right leaves it at bit 0
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: cnt <= bit_done ? '0 : cnt + 1'b1;
                STOP: begin
                    if (brk) begin
                        cnt <= '0;
                    end else if (bit_done) begin
                        cnt <= '0;
                        if (!rx_s) brk <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity check: the received bit must equal the configured parity of the data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            par_err      <= 1'b0;
            o_Parity_Err <= 1'b0;
        end else begin
            o_Parity_Err <= perr_d;
            if (state == IDLE) begin
                par_err <= 1'b0;
            end else if (state == PARITY && bit_done) begin
                par_err <= (rx_s != ((^shift) ^ (PARITY_ODD != 0)));
            end
        end
    end
`else
    assign par_err      = 1'b0;
    assign o_Parity_Err = 1'b0;
    logic unused_parity;
    assign unused_parity = perr_d ^ (PARITY_ODD != 0);
`endif

endmodule
